// File: rtl/mem_arbiter.sv
// mem_arbiter: lets an instruction cache and a data cache share one line-wide
// memory port, with a single transaction outstanding at a time.
// Build option: define MEM_ARB_RR_EN to arbitrate conflicts round-robin;
// left undefined, the D-side always wins over the I-side.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // instruction-cache side (reads only)
    input  logic                      ic_req_i,
    input  logic [ADDR_WIDTH-1:0]     ic_addr_i,
    output logic                      ic_gnt_o,
    output logic                      ic_rvalid_o,
    output logic [LINE_BYTES*8-1:0]   ic_rdata_o,
    // data-cache side (reads and writes)
    input  logic                      dc_req_i,
    input  logic                      dc_we_i,
    input  logic [ADDR_WIDTH-1:0]     dc_addr_i,
    input  logic [LINE_BYTES*8-1:0]   dc_wdata_i,
    output logic                      dc_gnt_o,
    output logic                      dc_rvalid_o,
    output logic [LINE_BYTES*8-1:0]   dc_rdata_o,
    output logic                      dc_write_done_o,
    // shared memory port
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [LINE_BYTES*8-1:0]   mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata_i,
    input  logic                      mem_write_done_i,
    // status
    output logic                      busy_o,
    output logic                      owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_WAIT_WR = 2'd3
    } state_e;

    state_e                    state_q;
    logic                      owner_q;    // 0 = I-side, 1 = D-side
    logic                      we_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [LINE_BYTES*8-1:0]   wdata_q;
    logic                      mem_req_q;
    logic                      busy_q;

    logic                      pick_dc_s;
    logic                      issue_gnt_s;
    logic                      rd_done_s;
    logic                      wr_done_s;

`ifdef MEM_ARB_RR_EN
    logic                      last_dc_q;  // 1 = D-side took the latest grant

    // On a conflict the side that was not granted last goes first
    assign pick_dc_s = dc_req_i & (~ic_req_i | ~last_dc_q);

    // Remember which side took the most recent memory grant
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_dc_q <= 1'b0;
        end else if ((state_q == ST_ISSUE) && mem_gnt_i) begin
            last_dc_q <= owner_q;
        end else begin
            last_dc_q <= last_dc_q;
        end
    end
`else
    // D-side has strict priority
    assign pick_dc_s = dc_req_i;
`endif

    // Transaction FSM: arbitrate in IDLE, hold the request in ISSUE, then wait for completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ic_req_i || dc_req_i) begin
                        owner_q   <= pick_dc_s;
                        // the I-side never writes
                        we_q      <= pick_dc_s & dc_we_i;
                        addr_q    <= pick_dc_s ? dc_addr_i : ic_addr_i;
                        wdata_q   <= pick_dc_s ? dc_wdata_i : '0;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= we_q ? ST_WAIT_WR : ST_WAIT_RD;
                    end else begin
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rvalid_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_WR: begin
                    if (mem_write_done_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_WR;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake events are only honoured in the state that expects them
    assign issue_gnt_s = (state_q == ST_ISSUE)   & mem_gnt_i;
    assign rd_done_s   = (state_q == ST_WAIT_RD) & mem_rvalid_i;
    assign wr_done_s   = (state_q == ST_WAIT_WR) & mem_write_done_i;

    // Per-side pulses steered to the owner only; read data is zero unless valid
    assign ic_gnt_o        = issue_gnt_s & ~owner_q;
    assign dc_gnt_o        = issue_gnt_s &  owner_q;
    assign ic_rvalid_o     = rd_done_s   & ~owner_q;
    assign dc_rvalid_o     = rd_done_s   &  owner_q;
    assign ic_rdata_o      = ic_rvalid_o ? mem_rdata_i : '0;
    assign dc_rdata_o      = dc_rvalid_o ? mem_rdata_i : '0;
    assign dc_write_done_o = wr_done_s   &  owner_q;

    // Memory request fields come straight from the latched registers
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = busy_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LB = 16;
    localparam int LW = LB * 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ic_req_i, ic_gnt_o, ic_rvalid_o;
    logic [AW-1:0] ic_addr_i;
    logic [LW-1:0] ic_rdata_o;
    logic          dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o, dc_write_done_o;
    logic [AW-1:0] dc_addr_i;
    logic [LW-1:0] dc_wdata_i, dc_rdata_o;
    logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_write_done_i;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_wdata_o, mem_rdata_i;
    logic          busy_o, owner_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
        .dc_write_done_o(dc_write_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_write_done_i(mem_write_done_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    task automatic idle_inputs();
        ic_req_i = 1'b0; ic_addr_i = '0;
        dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_write_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // All outputs are zero while reset is held, even with active inputs
    task automatic test_reset();
        logic [LW-1:0] pat;
        rst_i = 1'b0;
        idle_inputs();
        pat = {$urandom, $urandom, $urandom, $urandom};
        ic_req_i = 1'b1; dc_req_i = 1'b1; dc_we_i = 1'b1; ic_addr_i = 32'h0000_1234;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_write_done_i = 1'b1; mem_rdata_i = pat;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, busy_o, owner_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, dc_write_done_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b exp 000000000", {mem_req_o, mem_we_o, busy_o, owner_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, dc_write_done_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== '0 || ic_rdata_o !== '0 || dc_rdata_o !== '0) begin
            failures++;
            $display("FAIL reset_buses: addr=%h wdata=%h ic_rdata=%h dc_rdata=%h exp all 0", mem_addr_o, mem_wdata_o, ic_rdata_o, dc_rdata_o);
        end
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
    endtask

    // Lone I-side read with minimum grant latency
    task automatic test_ic_read();
        logic [LW-1:0] pat;
        pat = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5};
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_0100;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin failures++; $display("FAIL ic_c0_memreq: got %b exp 0", mem_req_o); end
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, ic_gnt_o, dc_gnt_o, owner_o} !== 5'b10100) begin
            failures++; $display("FAIL ic_c1_issue: got req,we,icg,dcg,own=%b exp 10100", {mem_req_o, mem_we_o, ic_gnt_o, dc_gnt_o, owner_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0000_0100) begin failures++; $display("FAIL ic_c1_addr: got %h exp 00000100", mem_addr_o); end
        @(negedge clk_i);
        ic_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, ic_gnt_o, ic_rvalid_o} !== 3'b100) begin
            failures++; $display("FAIL ic_c2_wait: got busy,icg,icv=%b exp 100", {busy_o, ic_gnt_o, ic_rvalid_o});
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b1; mem_rdata_i = pat;
        #1;
        checks++;
        if ({ic_rvalid_o, dc_rvalid_o, dc_gnt_o, dc_write_done_o} !== 4'b1000) begin
            failures++; $display("FAIL ic_c3_valid: got icv,dcv,dcg,dcwd=%b exp 1000", {ic_rvalid_o, dc_rvalid_o, dc_gnt_o, dc_write_done_o});
        end
        checks++;
        if (ic_rdata_o !== pat || dc_rdata_o !== '0) begin
            failures++; $display("FAIL ic_c3_rdata: got ic=%h dc=%h exp ic=%h dc=0", ic_rdata_o, dc_rdata_o, pat);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, ic_rvalid_o} !== 2'b00) begin failures++; $display("FAIL ic_c4_idle: got busy,icv=%b exp 00", {busy_o, ic_rvalid_o}); end
    endtask

    // D-side line write, completion pulse and busy release
    task automatic test_dc_write();
        logic [LW-1:0] pat;
        pat = {32'hCAFE_F00D, 32'h1111_2222, 32'h3333_4444, 32'h0F0F_F0F0};
        do_reset();
        dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h0000_2040; dc_wdata_i = pat;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, dc_gnt_o, ic_gnt_o, owner_o} !== 5'b11101) begin
            failures++; $display("FAIL dw_issue: got req,we,dcg,icg,own=%b exp 11101", {mem_req_o, mem_we_o, dc_gnt_o, ic_gnt_o, owner_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0000_2040 || mem_wdata_o !== pat) begin
            failures++; $display("FAIL dw_fields: got addr=%h wdata=%h exp addr=00002040 wdata=%h", mem_addr_o, mem_wdata_o, pat);
        end
        @(negedge clk_i);
        dc_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if ({dc_rvalid_o, dc_write_done_o, busy_o} !== 3'b001) begin
            failures++; $display("FAIL dw_wait: got dcv,dcwd,busy=%b exp 001", {dc_rvalid_o, dc_write_done_o, busy_o});
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0; mem_write_done_i = 1'b1;
        #1;
        checks++;
        if ({dc_write_done_o, ic_rvalid_o, dc_rvalid_o} !== 3'b100) begin
            failures++; $display("FAIL dw_done: got dcwd,icv,dcv=%b exp 100", {dc_write_done_o, ic_rvalid_o, dc_rvalid_o});
        end
        @(negedge clk_i);
        mem_write_done_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, dc_write_done_o} !== 2'b00) begin failures++; $display("FAIL dw_after: got busy,dcwd=%b exp 00", {busy_o, dc_write_done_o}); end
    endtask

    // Both sides requesting back to back: fixed D priority or alternating order
    task automatic test_conflict();
        logic exp_d;
        int   t;
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_0A00;
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_0D00;
        for (int k = 0; k < 4; k++) begin
            exp_d = RR ? (k % 2 == 0) : (k < 3);
            if (!RR && k == 3) dc_req_i = 1'b0;
            t = 0;
            while (mem_req_o !== 1'b1 && t < 10) begin @(negedge clk_i); t++; end
            checks++;
            if (t >= 10) begin failures++; $display("FAIL conflict_timeout: txn %0d got no mem_req_o within %0d cycles", k, t); end
            mem_gnt_i = 1'b1;
            #1;
            checks++;
            if ({dc_gnt_o, ic_gnt_o} !== {exp_d, ~exp_d}) begin
                failures++; $display("FAIL conflict_order: txn %0d got dcg,icg=%b%b exp %b%b", k, dc_gnt_o, ic_gnt_o, exp_d, ~exp_d);
            end
            checks++;
            if (mem_addr_o !== (exp_d ? 32'h0000_0D00 : 32'h0000_0A00)) begin
                failures++; $display("FAIL conflict_addr: txn %0d got %h", k, mem_addr_o);
            end
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
        end
        idle_inputs();
    endtask

    // Reset in the middle of a read abandons it without a completion pulse
    task automatic test_reset_mid();
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_0300;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        ic_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, mem_req_o, owner_o} !== 3'b000) begin failures++; $display("FAIL rstmid_async: got busy,req,own=%b exp 000", {busy_o, mem_req_o, owner_o}); end
        @(negedge clk_i);
        rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = {4{32'h7777_8888}};
        #1;
        checks++;
        if ({ic_rvalid_o, dc_rvalid_o, busy_o} !== 3'b000 || ic_rdata_o !== '0) begin
            failures++; $display("FAIL rstmid_rvalid: got icv,dcv,busy=%b rdata=%h exp 000 and 0", {ic_rvalid_o, dc_rvalid_o, busy_o}, ic_rdata_o);
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, busy_o, owner_o} !== 4'b0000 || mem_addr_o !== 32'h0 || mem_wdata_o !== '0) begin
            failures++; $display("FAIL rstmid_outputs: got flags=%b addr=%h exp 0", {mem_req_o, mem_we_o, busy_o, owner_o}, mem_addr_o);
        end
    endtask

    // Stray completions in IDLE are ignored; fields hold while the grant is withheld
    task automatic test_stray_hold();
        logic [AW-1:0] a;
        do_reset();
        mem_rvalid_i = 1'b1; mem_write_done_i = 1'b1;
        #1;
        checks++;
        if ({ic_rvalid_o, dc_rvalid_o, dc_write_done_o, ic_gnt_o, dc_gnt_o} !== 5'b0) begin
            failures++; $display("FAIL stray_idle: got %b exp 00000", {ic_rvalid_o, dc_rvalid_o, dc_write_done_o, ic_gnt_o, dc_gnt_o});
        end
        @(negedge clk_i);
        a = $urandom;
        mem_rvalid_i = 1'b0; mem_write_done_i = 1'b0;
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = a;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL stray_busy: got %b exp 0", busy_o); end
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            mem_rvalid_i = i[0];
            #1;
            checks++;
            if (mem_addr_o !== a || mem_req_o !== 1'b1 || dc_gnt_o !== 1'b0 || dc_rvalid_o !== 1'b0) begin
                failures++; $display("FAIL hold_issue: cycle %0d got addr=%h req=%b dcg=%b dcv=%b exp addr=%h req=1 dcg=0 dcv=0", i, mem_addr_o, mem_req_o, dc_gnt_o, dc_rvalid_o, a);
            end
            @(negedge clk_i);
        end
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (dc_gnt_o !== 1'b1) begin failures++; $display("FAIL hold_gnt: got %b exp 1", dc_gnt_o); end
        @(negedge clk_i);
        mem_gnt_i = 1'b0; dc_req_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (dc_rvalid_o !== 1'b1) begin failures++; $display("FAIL hold_rvalid: got %b exp 1", dc_rvalid_o); end
        @(negedge clk_i);
        idle_inputs();
    endtask

    // Random requesters and memory timing against a transaction-level model
    task automatic test_random(input int ncyc);
        int            ph;          // 0 none, 1 waiting grant, 2 read outstanding, 3 write outstanding
        int            dly, done, ntx;
        logic          own, lg, win, p_ic, p_dc, g, rv, wd;
        logic          ic_pend, dc_pend, dc_we_m, exp_we;
        logic [AW-1:0] ic_a, dc_a, exp_addr;
        logic [LW-1:0] dc_wd, exp_wd, rdat;
        do_reset();
        ph = 0; dly = 0; done = -5; ntx = 0; own = 1'b0; lg = 1'b0;
        p_ic = 1'b0; p_dc = 1'b0; ic_pend = 1'b0; dc_pend = 1'b0; dc_we_m = 1'b0;
        ic_a = '0; dc_a = '0; dc_wd = '0; exp_addr = '0; exp_wd = '0; exp_we = 1'b0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (ph == 0) begin
                if (mem_req_o === 1'b1) begin
                    checks++;
                    if (!(p_ic || p_dc) || (cyc - 1 <= done)) begin
                        failures++; $display("FAIL rnd_spurious_issue: cycle %0d req_prev=%b%b last_done=%0d", cyc, p_ic, p_dc, done);
                    end
                    win      = (p_ic && p_dc) ? (RR ? ~lg : 1'b1) : p_dc;
                    exp_addr = win ? dc_a : ic_a;
                    exp_we   = win ? dc_we_m : 1'b0;
                    exp_wd   = dc_wd;
                    checks++;
                    if (owner_o !== win || mem_we_o !== exp_we) begin
                        failures++; $display("FAIL rnd_winner: cycle %0d got own=%b we=%b exp own=%b we=%b", cyc, owner_o, mem_we_o, win, exp_we);
                    end
                    if (exp_we) begin
                        checks++;
                        if (mem_wdata_o !== exp_wd) begin failures++; $display("FAIL rnd_wdata: cycle %0d got %h exp %h", cyc, mem_wdata_o, exp_wd); end
                    end
                    ph = 1; own = win; dly = $urandom_range(0, 3);
                end else begin
                    checks++;
                    if ((p_ic || p_dc) && (cyc - 1 > done)) begin
                        failures++; $display("FAIL rnd_missing_issue: cycle %0d got mem_req_o=%b exp 1", cyc, mem_req_o);
                    end
                end
            end
            checks++;
            if (busy_o !== (ph != 0) || mem_req_o !== (ph == 1)) begin
                failures++; $display("FAIL rnd_status: cycle %0d got busy=%b req=%b exp busy=%b req=%b", cyc, busy_o, mem_req_o, ph != 0, ph == 1);
            end
            if (ph == 1) begin
                checks++;
                if (mem_addr_o !== exp_addr) begin failures++; $display("FAIL rnd_addr: cycle %0d got %h exp %h", cyc, mem_addr_o, exp_addr); end
            end
            // requesters hold a pending request until granted
            if (!ic_pend && $urandom_range(0, 3) == 0) begin ic_pend = 1'b1; ic_a = $urandom; end
            if (!dc_pend && $urandom_range(0, 3) == 0) begin
                dc_pend = 1'b1; dc_a = $urandom; dc_we_m = $urandom_range(0, 1);
                dc_wd = {$urandom, $urandom, $urandom, $urandom};
            end
            ic_req_i = ic_pend; ic_addr_i = ic_pend ? ic_a : $urandom;
            dc_req_i = dc_pend; dc_addr_i = dc_pend ? dc_a : $urandom;
            dc_we_i = dc_pend ? dc_we_m : 1'($urandom_range(0, 1));
            dc_wdata_i = dc_pend ? dc_wd : {$urandom, $urandom, $urandom, $urandom};
            // memory side, including stray completions outside their phase
            g = 1'b0;
            if (ph == 1) begin g = (dly == 0); if (dly > 0) dly--; end
            if (ph == 2) begin rv = (dly == 0); if (dly > 0) dly--; end
            else rv = ($urandom_range(0, 3) == 0);
            if (ph == 3) begin wd = (dly == 0); if (dly > 0) dly--; end
            else wd = ($urandom_range(0, 3) == 0);
            rdat = {$urandom, $urandom, $urandom, $urandom};
            mem_gnt_i = g; mem_rvalid_i = rv; mem_write_done_i = wd; mem_rdata_i = rdat;
            #1;
            checks++;
            if ({ic_gnt_o, dc_gnt_o} !== {g && !own, g && own}) begin
                failures++; $display("FAIL rnd_gnt: cycle %0d got icg,dcg=%b%b exp %b%b", cyc, ic_gnt_o, dc_gnt_o, g && !own, g && own);
            end
            checks++;
            if ({ic_rvalid_o, dc_rvalid_o, dc_write_done_o} !== {ph == 2 && rv && !own, ph == 2 && rv && own, ph == 3 && wd}) begin
                failures++; $display("FAIL rnd_resp: cycle %0d got icv,dcv,dcwd=%b exp %b", cyc, {ic_rvalid_o, dc_rvalid_o, dc_write_done_o}, {ph == 2 && rv && !own, ph == 2 && rv && own, ph == 3 && wd});
            end
            checks++;
            if (ic_rdata_o !== ((ph == 2 && rv && !own) ? rdat : '0) || dc_rdata_o !== ((ph == 2 && rv && own) ? rdat : '0)) begin
                failures++; $display("FAIL rnd_rdata: cycle %0d got ic=%h dc=%h", cyc, ic_rdata_o, dc_rdata_o);
            end
            if (g) begin
                lg = own;
                if (own) dc_pend = 1'b0;
                else ic_pend = 1'b0;
                ph = exp_we ? 3 : 2;
                dly = $urandom_range(0, 3);
            end else if ((ph == 2 && rv) || (ph == 3 && wd)) begin
                ph = 0; done = cyc; ntx++;
            end
            p_ic = ic_req_i; p_dc = dc_req_i;
            @(negedge clk_i);
        end
        checks++;
        if (ntx < 20) begin failures++; $display("FAIL rnd_progress: got %0d transactions exp at least 20", ntx); end
        idle_inputs();
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        test_reset();
        test_ic_read();
        test_dc_write();
        test_conflict();
        test_reset_mid();
        test_stray_hold();
        test_random(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
